// File: rtl/m_free_list_mp.sv
// Multi-port flop-based free-list allocator: NA ports each offer the (k+1)-th lowest free entry.
// Optional double-free detection is built only when FL_DFREE_CHK_EN is defined.
module m_free_list_mp #(
  parameter int EN = 8,
  parameter int NA = 2,
  localparam int IDX_W  = $clog2(EN),
  localparam int USED_W = $clog2(EN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic [NA-1:0]       fl_vld,
  input  logic [NA-1:0]       fl_rdy,
  output logic [NA*IDX_W-1:0] fl_idx,
  output logic [NA*EN-1:0]    fl_oh,
  input  logic                ret_vld,
  output logic                ret_rdy,
  input  logic [EN-1:0]       ret,
  output logic [USED_W-1:0]   used,
  output logic                err_dfree
);

  logic [EN-1:0]     free_q;
  logic [USED_W-1:0] used_q;
  logic              init_q;

  logic [USED_W-1:0] free_cnt;
  logic [EN-1:0]     alloc_mask;
  logic [EN-1:0]     ret_acc_mask;
  logic [EN-1:0]     ret_eff_mask;
  logic [EN-1:0]     free_d;
  logic [USED_W-1:0] used_d;

  assign free_cnt = USED_W'($countones(free_q));

  // Offers come only from registers and flush, never from fl_rdy or ret.
  always_comb begin
    int rank;
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    fl_idx = '0;
    fl_oh  = '0;
    rank   = 0;
    for (int i = 0; i < EN; i++) begin
      if (free_q[i]) begin
        for (int k = 0; k < NA; k++) begin
          if (rank == k) begin
            fl_oh[k*EN + i]          = 1'b1;
            fl_idx[k*IDX_W +: IDX_W] = IDX_W'(i);
          end
        end
        rank++;
      end
    end
  end

  always_comb begin
    fl_vld     = '0;
    alloc_mask = '0;
    for (int k = 0; k < NA; k++) begin
      fl_vld[k] = init_q & ~flush & (int'(free_cnt) > k);
      if (fl_vld[k] && fl_rdy[k]) alloc_mask = alloc_mask | fl_oh[k*EN +: EN];
    end
  end

  assign ret_rdy      = init_q;
  assign ret_acc_mask = (ret_vld && init_q) ? ret : '0;
  // Returns of free entries or of entries allocated this cycle are ignored; allocation wins.
  assign ret_eff_mask = ret_acc_mask & ~free_q & ~alloc_mask;
  assign free_d       = (free_q & ~alloc_mask) | ret_eff_mask;
  assign used_d       = used_q + USED_W'($countones(alloc_mask))
                               - USED_W'($countones(ret_eff_mask));
  assign used         = used_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= '1;
      used_q <= '0;
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (flush) begin
        free_q <= '1;
        used_q <= '0;
      end else begin
        free_q <= free_d;
        used_q <= used_d;
      end
    end
  end

`ifdef FL_DFREE_CHK_EN
  logic [EN-1:0] dfree_mask;
  logic          err_q;

  assign dfree_mask = ret_acc_mask & (free_q | alloc_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (|dfree_mask) & ~flush;
  end

  assign err_dfree = err_q;
`else
  assign err_dfree = 1'b0;
`endif

endmodule

// File: tb/tb_m_free_list_mp.sv
// Scoreboard bench for m_free_list_mp: driver pushes model expectations, monitor pops and compares.
module tb_m_free_list_mp;
  localparam int EN = 8;
  localparam int NA = 2;
  localparam int IDX_W  = $clog2(EN);
  localparam int USED_W = $clog2(EN + 1);
`ifdef FL_DFREE_CHK_EN
  localparam bit DF_EN = 1'b1;
`else
  localparam bit DF_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic [NA-1:0]       fl_vld;
  logic [NA-1:0]       fl_rdy = '0;
  logic [NA*IDX_W-1:0] fl_idx;
  logic [NA*EN-1:0]    fl_oh;
  logic                ret_vld = 1'b0;
  logic                ret_rdy;
  logic [EN-1:0]       ret = '0;
  logic [USED_W-1:0]   used;
  logic                err_dfree;

  m_free_list_mp #(.EN(EN), .NA(NA)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fl_vld(fl_vld), .fl_rdy(fl_rdy), .fl_idx(fl_idx), .fl_oh(fl_oh),
    .ret_vld(ret_vld), .ret_rdy(ret_rdy), .ret(ret),
    .used(used), .err_dfree(err_dfree)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [NA-1:0] vld;
    int          idx [NA];
    int          used;
    bit          rdy;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Reference model: a set of free entries, kept as a flag per entry.
  bit free_m [EN];
  bit init_m;
  bit err_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (free_m[i]) free_m[i] = 1'b1;
    init_m = 1'b0;
    err_m  = 1'b0;
  endtask

  function automatic int popcnt_free();
    int n = 0;
    foreach (free_m[i]) if (free_m[i]) n++;
    return n;
  endfunction

  task automatic step(input bit rst_v, input bit fl_v, input bit [NA-1:0] rdy_v,
                      input bit rv, input bit [EN-1:0] ret_v);
    int   fq[$];
    exp_t e;
    bit   am [EN];
    bit   df;
    @(negedge clk);
    rst_n = rst_v; flush = fl_v; fl_rdy = rdy_v; ret_vld = rv; ret = ret_v;
    if (!rst_v) model_reset();
    for (int i = 0; i < EN; i++) if (free_m[i]) fq.push_back(i);
    for (int k = 0; k < NA; k++) begin
      e.vld[k] = init_m && !fl_v && (fq.size() > k);
      e.idx[k] = (fq.size() > k) ? fq[k] : 0;
    end
    e.used = EN - fq.size();
    e.rdy  = init_m;
    e.err  = err_m;
    sb.push_back(e);
    @(posedge clk);
    if (!rst_v) return;
    df = 1'b0;
    foreach (am[i]) am[i] = 1'b0;
    if (init_m && fl_v) begin
      foreach (free_m[i]) free_m[i] = 1'b1;
    end else if (init_m) begin
      for (int k = 0; k < NA; k++) if (e.vld[k] && rdy_v[k]) am[fq[k]] = 1'b1;
      for (int i = 0; i < EN; i++) begin
        if (rv && ret_v[i] && (free_m[i] || am[i])) df = 1'b1;
        if (am[i])                  free_m[i] = 1'b0;
        else if (rv && ret_v[i])    free_m[i] = 1'b1;
      end
    end
    err_m  = DF_EN && df;
    init_m = 1'b1;
  endtask

  task automatic idle(); step(1'b1, 1'b0, '0, 1'b0, '0); endtask

  // Monitor: compares the DUT against the oldest expectation, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_vld", fl_vld, e.vld);
        for (int k = 0; k < NA; k++)
          if (e.vld[k]) check($sformatf("sb_idx%0d", k), fl_idx[k*IDX_W +: IDX_W], e.idx[k]);
        for (int k = 0; k < NA; k++)
          if (e.vld[k]) check($sformatf("sb_oh%0d", k), fl_oh[k*EN +: EN], 1 << e.idx[k]);
        check("sb_used", used, e.used);
        check("sb_ret_rdy", ret_rdy, e.rdy);
        check("sb_err", err_dfree, e.err);
      end
    end
  end

  initial begin
    bit [EN-1:0] alloc_set;
    bit [EN-1:0] rmask;
    model_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    #1;
    check("rel_vld", fl_vld, 2'b11);
    check("rel_idx0", fl_idx[0 +: IDX_W], 0);
    check("rel_idx1", fl_idx[IDX_W +: IDX_W], 1);
    check("rel_rdy", ret_rdy, 1);
    step(1'b1, 1'b0, 2'b11, 1'b0, '0);
    #1;
    check("a1_idx0", fl_idx[0 +: IDX_W], 2);
    check("a1_idx1", fl_idx[IDX_W +: IDX_W], 3);
    check("a1_used", used, 2);
    step(1'b1, 1'b0, 2'b10, 1'b0, '0);
    #1;
    check("a2_idx0", fl_idx[0 +: IDX_W], 2);
    check("a2_idx1", fl_idx[IDX_W +: IDX_W], 4);
    check("a2_used", used, 3);

    step(1'b1, 1'b1, '0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 2'b11, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 8'b0000_0101);
    #1;
    check("ret_idx0", fl_idx[0 +: IDX_W], 0);
    check("ret_idx1", fl_idx[IDX_W +: IDX_W], 2);
    check("ret_used", used, 2);

    step(1'b1, 1'b1, '0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, 2'b11, 1'b0, '0);
    #1;
    check("full_vld", fl_vld, 2'b00);
    check("full_used", used, 8);
    step(1'b1, 1'b0, '0, 1'b1, 8'h80);
    #1;
    check("f7_vld", fl_vld, 2'b01);
    check("f7_idx0", fl_idx[0 +: IDX_W], 7);
    step(1'b1, 1'b0, 2'b01, 1'b1, 8'h01);
    #1;
    check("swap_used", used, 7);
    check("swap_idx0", fl_idx[0 +: IDX_W], 0);

    step(1'b1, 1'b1, '0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, 1'b0, '0);
    step(1'b1, 1'b0, 2'b01, 1'b0, '0);
    step(1'b1, 1'b1, 2'b11, 1'b0, '0);
    #1;
    check("fl_vld0", fl_vld, 2'b00);
    idle();
    #1;
    check("fl_used", used, 0);
    check("fl_idx0", fl_idx[0 +: IDX_W], 0);
    check("fl_idx1", fl_idx[IDX_W +: IDX_W], 1);

    step(1'b1, 1'b0, '0, 1'b1, 8'h40);
    #1;
    check("df_err", err_dfree, DF_EN);
    check("df_used", used, 0);
    idle();
    #1;
    check("df_pulse", err_dfree, 0);

    for (int n = 0; n < 3000; n++) begin
      alloc_set = '0;
      for (int i = 0; i < EN; i++) alloc_set[i] = !free_m[i];
      rmask = alloc_set & EN'($urandom);
      if ($urandom_range(7) == 0) rmask = rmask ^ EN'($urandom);
      if ($urandom_range(299) == 0)
        step(1'b0, 1'b0, NA'($urandom), 1'b1, rmask);
      else
        step(1'b1, $urandom_range(39) == 0, NA'($urandom), $urandom_range(2) != 0, rmask);
    end
    idle();
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
